// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the data-memory responder and the core top.
package mem_responder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } mem_rsp_state_t;

   // Fibonacci taps 8,6,5,4 expressed as bit positions 7,5,4,3
   localparam logic [7:0]  LFSR_TAPS = 8'hB8;

   localparam logic [31:0] MEM_BASE  = 32'h8000_0000;
   localparam logic [31:0] MEM_SIZE  = 32'h0800_0000;

endpackage

// File: rtl/pmem_dpi_pkg.sv
// Behavioural pmem_read/pmem_write with the same call signatures as the core's DPI-C imports.
// Backed by a sparse word array, with call counters and the last mask seen on each path.
package pmem_dpi_pkg;

   logic [31:0] pmem_words [int unsigned];
   int unsigned pmem_reads;
   int unsigned pmem_writes;
   logic [7:0]  pmem_last_rmask;
   logic [7:0]  pmem_last_wmask;

   function automatic int pmem_read(input int raddr, input byte rmask);
      logic [31:0] key;
      key = 32'(raddr) >> 2;
      pmem_reads++;
      pmem_last_rmask = 8'(rmask);
      if (pmem_words.exists(key)) return int'(pmem_words[key]);
      return 0;
   endfunction

   // Byte lanes 0..3 of the word are updated where the mask bit is set
   function automatic void pmem_write(input int waddr, input int wdata, input byte wmask);
      logic [31:0] key;
      logic [31:0] word;
      logic [31:0] data;
      key  = 32'(waddr) >> 2;
      data = 32'(wdata);
      word = pmem_words.exists(key) ? pmem_words[key] : 32'h0;
      for (int b = 0; b < 4; b++) begin
         if (wmask[b]) word[8*b +: 8] = data[8*b +: 8];
      end
      pmem_words[key] = word;
      pmem_writes++;
      pmem_last_wmask = 8'(wmask);
   endfunction

endpackage

// File: rtl/lfsr8.sv
// 8-bit Fibonacci LFSR, advancing one step per cycle that en is high.
module lfsr8
   import mem_responder_pkg::*;
#(
   parameter logic [7:0] SEED = 8'hA5,
   parameter logic [7:0] TAPS = LFSR_TAPS
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   output logic [7:0] value
);

   logic [7:0] lfsr_q;
   logic [7:0] lfsr_d;

   always_comb begin
      lfsr_d = lfsr_q;
      if (en) lfsr_d = {lfsr_q[6:0], ^(lfsr_q & TAPS)};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) lfsr_q <= SEED;
      else        lfsr_q <= lfsr_d;
   end

   assign value = lfsr_q;

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder: accepts a request, waits a (optionally randomized)
// latency, performs the pmem access once on the WAIT->RESP edge and holds the response.
module mem_responder
   import mem_responder_pkg::*;
   import pmem_dpi_pkg::*;
#(
   parameter int          LATENCY    = 1,
   parameter bit          RAND_DELAY = 1'b0,
   parameter int unsigned DLY_BITS   = 2,
   parameter logic [7:0]  SEED       = 8'hA5,
   parameter logic [31:0] BASE       = MEM_BASE,
   parameter logic [31:0] SIZE       = MEM_SIZE
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_wen,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [7:0]  req_mask,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        rsp_wen
);

   localparam int unsigned CNT_W     = 32;
   localparam int unsigned LAT_MIN   = (LATENCY < 1) ? 32'd1 : 32'(LATENCY);
   localparam logic [32:0] RANGE_LO  = 33'(BASE);
   localparam logic [32:0] RANGE_END = 33'(BASE) + 33'(SIZE);

   mem_rsp_state_t    state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              wen_q, wen_d;
   logic [31:0]       addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [7:0]        mask_q, mask_d;
   logic              req_ready_q, req_ready_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [31:0]       rsp_rdata_q;
   logic              rsp_err_q;
   logic              rsp_wen_q;

   logic [7:0]        lfsr_val;
   logic              accept_c;
   logic              access_c;
   logic              in_range_c;
   logic [CNT_W-1:0]  dly_c;
   logic [CNT_W-1:0]  lat_c;

   lfsr8 #(
      .SEED (SEED),
      .TAPS (LFSR_TAPS)
   ) u_lfsr (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (accept_c),
      .value (lfsr_val)
   );

   // The pre-advance LFSR value sets the extra delay of the request being accepted
   assign dly_c      = RAND_DELAY ? CNT_W'(lfsr_val[DLY_BITS-1:0]) : '0;
   assign lat_c      = CNT_W'(LAT_MIN) + dly_c;
   assign in_range_c = ({1'b0, addr_q} >= RANGE_LO) && ({1'b0, addr_q} < RANGE_END);

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      wen_d    = wen_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      mask_d   = mask_q;
      accept_c = 1'b0;
      access_c = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               accept_c = 1'b1;
               wen_d    = req_wen;
               addr_d   = req_addr;
               wdata_d  = req_wdata;
               mask_d   = req_mask;
               cnt_d    = lat_c - CNT_W'(1);
               state_d  = WAIT;
            end
         end
         WAIT: begin
            if (cnt_q == '0) begin
               access_c = 1'b1;
               state_d  = RESP;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         RESP: begin
            if (rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      req_ready_d = (state_d == IDLE);
      rsp_valid_d = (state_d == RESP);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         wen_q       <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         mask_q      <= '0;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         wen_q       <= wen_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         mask_q      <= mask_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
      end
   end

   // Memory access happens here only, so each request touches pmem at most once
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
         rsp_wen_q   <= 1'b0;
      end else if (access_c) begin
         rsp_wen_q   <= wen_q;
         rsp_err_q   <= !in_range_c;
         rsp_rdata_q <= '0;
         if (in_range_c) begin
            if (wen_q) pmem_write(32'(addr_q), 32'(wdata_q), 8'(mask_q));
            else       rsp_rdata_q <= 32'(pmem_read(32'(addr_q), 8'(mask_q)));
         end
      end
   end

   assign req_ready = req_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;
   assign rsp_wen   = rsp_wen_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: four instances (L=1, L=3, L=4, L=1 with random delay) checked
// against a word-array memory model, a range rule and an LFSR sequence kept in the bench.
module tb_mem_responder;

   localparam int          NI   = 4;
   localparam logic [31:0] BASE = 32'h8000_0000;
   localparam logic [31:0] SIZE = 32'h0800_0000;

   logic        clk;
   logic        rst_n;
   logic        req_valid [NI];
   logic        req_ready [NI];
   logic        req_wen   [NI];
   logic [31:0] req_addr  [NI];
   logic [31:0] req_wdata [NI];
   logic [7:0]  req_mask  [NI];
   logic        rsp_valid [NI];
   logic        rsp_ready [NI];
   logic [31:0] rsp_rdata [NI];
   logic        rsp_err   [NI];
   logic        rsp_wen   [NI];

   int n_checks;
   int n_fail;
   logic [31:0] ref_mem [int unsigned];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      mem_responder #(
         .LATENCY    ((g == 1) ? 3 : (g == 2) ? 4 : 1),
         .RAND_DELAY (g == 3),
         .DLY_BITS   (2),
         .SEED       (8'hA5),
         .BASE       (BASE),
         .SIZE       (SIZE)
      ) u_dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .req_valid (req_valid[g]),
         .req_ready (req_ready[g]),
         .req_wen   (req_wen[g]),
         .req_addr  (req_addr[g]),
         .req_wdata (req_wdata[g]),
         .req_mask  (req_mask[g]),
         .rsp_valid (rsp_valid[g]),
         .rsp_ready (rsp_ready[g]),
         .rsp_rdata (rsp_rdata[g]),
         .rsp_err   (rsp_err[g]),
         .rsp_wen   (rsp_wen[g])
      );
   end

   function automatic bit ref_in_range(input logic [31:0] a);
      longint unsigned x;
      x = 64'(a);
      return (x >= 64'(BASE)) && (x < 64'(BASE) + 64'(SIZE));
   endfunction

   function automatic logic [31:0] ref_read(input logic [31:0] a);
      int unsigned key;
      key = a >> 2;
      return ref_mem.exists(key) ? ref_mem[key] : 32'h0;
   endfunction

   function automatic void ref_write(input logic [31:0] a, input logic [31:0] d, input logic [7:0] m);
      logic [31:0] w;
      w = ref_read(a);
      for (int b = 0; b < 4; b++) if (m[b]) w[8*b +: 8] = d[8*b +: 8];
      ref_mem[a >> 2] = w;
   endfunction

   // Shift left; the new bit is the XOR of stages 8, 6, 5 and 4
   function automatic logic [7:0] lfsr_next(input logic [7:0] s);
      return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
   endfunction

   // Present one request, wait for acceptance, then count cycles until rsp_valid (-1 if never)
   task automatic issue(input int i, input logic wen, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [7:0] mask, output int lat);
      int guard;
      guard = 0;
      lat   = -1;
      @(negedge clk);
      while (!req_ready[i] && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      req_valid[i] = 1'b1;
      req_wen[i]   = wen;
      req_addr[i]  = addr;
      req_wdata[i] = wdata;
      req_mask[i]  = mask;
      @(posedge clk);
      #1;
      req_valid[i] = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         @(posedge clk);
         #1;
         if (rsp_valid[i]) begin
            lat = c;
            break;
         end
      end
   endtask

   task automatic consume(input int i);
      rsp_ready[i] = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready[i] = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      for (int i = 0; i < NI; i++) begin
         req_valid[i] = 1'b0; req_wen[i] = 1'b0; req_addr[i] = '0;
         req_wdata[i] = '0;   req_mask[i] = '0;  rsp_ready[i] = 1'b0;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < NI; i++) begin
         n_checks += 5;
         if (req_ready[i] !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready[%0d]: got %b expected 1", i, req_ready[i]); end
         if (rsp_valid[i] !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid[%0d]: got %b expected 0", i, rsp_valid[i]); end
         if (rsp_rdata[i] !== 32'h0) begin n_fail++; $display("FAIL reset_rsp_rdata[%0d]: got %h expected 0", i, rsp_rdata[i]); end
         if (rsp_err[i] !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_err[%0d]: got %b expected 0", i, rsp_err[i]); end
         if (rsp_wen[i] !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_wen[%0d]: got %b expected 0", i, rsp_wen[i]); end
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < NI; i++) begin
         n_checks++;
         if (req_ready[i] !== 1'b1 || rsp_valid[i] !== 1'b0) begin
            n_fail++; $display("FAIL post_reset_idle[%0d]: got ready=%b valid=%b expected ready=1 valid=0", i, req_ready[i], rsp_valid[i]);
         end
      end
   endtask

   task automatic test_read_l1();
      int lat;
      int unsigned r0;
      issue(0, 1'b1, BASE, 32'hDEAD_BEEF, 8'h0F, lat);
      ref_write(BASE, 32'hDEAD_BEEF, 8'h0F);
      consume(0);
      r0 = pmem_dpi_pkg::pmem_reads;
      issue(0, 1'b0, BASE, 32'h0, 8'h0F, lat);
      n_checks += 6;
      if (lat !== 1) begin n_fail++; $display("FAIL read_l1_latency: got %0d expected 1", lat); end
      if (rsp_rdata[0] !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL read_l1_rdata: got %h expected deadbeef", rsp_rdata[0]); end
      if (rsp_err[0] !== 1'b0) begin n_fail++; $display("FAIL read_l1_err: got %b expected 0", rsp_err[0]); end
      if (rsp_wen[0] !== 1'b0) begin n_fail++; $display("FAIL read_l1_wen: got %b expected 0", rsp_wen[0]); end
      if (pmem_dpi_pkg::pmem_reads - r0 !== 1) begin n_fail++; $display("FAIL read_l1_calls: got %0d expected 1", pmem_dpi_pkg::pmem_reads - r0); end
      if (pmem_dpi_pkg::pmem_last_rmask !== 8'h0F) begin n_fail++; $display("FAIL read_l1_mask: got %h expected 0f", pmem_dpi_pkg::pmem_last_rmask); end
      consume(0);
      n_checks++;
      if (req_ready[0] !== 1'b1 || rsp_valid[0] !== 1'b0) begin
         n_fail++; $display("FAIL read_l1_idle: got ready=%b valid=%b expected ready=1 valid=0", req_ready[0], rsp_valid[0]);
      end
   endtask

   task automatic test_write_read_l3();
      int lat;
      int unsigned w0;
      w0 = pmem_dpi_pkg::pmem_writes;
      issue(1, 1'b1, BASE + 32'h10, 32'h1234_5678, 8'h0F, lat);
      ref_write(BASE + 32'h10, 32'h1234_5678, 8'h0F);
      n_checks += 6;
      if (lat !== 3) begin n_fail++; $display("FAIL write_l3_latency: got %0d expected 3", lat); end
      if (rsp_wen[1] !== 1'b1) begin n_fail++; $display("FAIL write_l3_wen: got %b expected 1", rsp_wen[1]); end
      if (rsp_rdata[1] !== 32'h0) begin n_fail++; $display("FAIL write_l3_rdata: got %h expected 0", rsp_rdata[1]); end
      if (rsp_err[1] !== 1'b0) begin n_fail++; $display("FAIL write_l3_err: got %b expected 0", rsp_err[1]); end
      if (pmem_dpi_pkg::pmem_writes - w0 !== 1) begin n_fail++; $display("FAIL write_l3_calls: got %0d expected 1", pmem_dpi_pkg::pmem_writes - w0); end
      if (pmem_dpi_pkg::pmem_last_wmask !== 8'h0F) begin n_fail++; $display("FAIL write_l3_mask: got %h expected 0f", pmem_dpi_pkg::pmem_last_wmask); end
      consume(1);
      issue(1, 1'b0, BASE + 32'h10, 32'h0, 8'h0F, lat);
      n_checks += 2;
      if (lat !== 3) begin n_fail++; $display("FAIL read_l3_latency: got %0d expected 3", lat); end
      if (rsp_rdata[1] !== 32'h1234_5678) begin n_fail++; $display("FAIL read_l3_rdata: got %h expected 12345678", rsp_rdata[1]); end
      consume(1);
   endtask

   task automatic test_address_range();
      logic [31:0] addrs [6];
      int lat;
      int unsigned c0;
      bit exp_err;
      addrs = '{32'h0000_1000, BASE - 32'd4, BASE, BASE + SIZE - 32'd4, BASE + SIZE, 32'hFFFF_FFFC};
      for (int k = 0; k < 6; k++) begin
         exp_err = !ref_in_range(addrs[k]);
         c0 = pmem_dpi_pkg::pmem_reads;
         issue(0, 1'b0, addrs[k], 32'h0, 8'h0F, lat);
         n_checks += 3;
         if (rsp_err[0] !== exp_err) begin n_fail++; $display("FAIL range_err @%h: got %b expected %b", addrs[k], rsp_err[0], exp_err); end
         if (rsp_rdata[0] !== (exp_err ? 32'h0 : ref_read(addrs[k]))) begin
            n_fail++; $display("FAIL range_rdata @%h: got %h expected %h", addrs[k], rsp_rdata[0], exp_err ? 32'h0 : ref_read(addrs[k]));
         end
         if (pmem_dpi_pkg::pmem_reads - c0 !== (exp_err ? 0 : 1)) begin
            n_fail++; $display("FAIL range_calls @%h: got %0d expected %0d", addrs[k], pmem_dpi_pkg::pmem_reads - c0, exp_err ? 0 : 1);
         end
         consume(0);
      end
      c0 = pmem_dpi_pkg::pmem_writes;
      issue(0, 1'b1, BASE + SIZE, 32'hCAFE_F00D, 8'h0F, lat);
      n_checks += 2;
      if (pmem_dpi_pkg::pmem_writes - c0 !== 0) begin n_fail++; $display("FAIL range_bad_write_calls: got %0d expected 0", pmem_dpi_pkg::pmem_writes - c0); end
      if (rsp_err[0] !== 1'b1 || rsp_wen[0] !== 1'b1) begin
         n_fail++; $display("FAIL range_bad_write_rsp: got err=%b wen=%b expected err=1 wen=1", rsp_err[0], rsp_wen[0]);
      end
      consume(0);
   endtask

   task automatic test_backpressure();
      int lat;
      int unsigned w0;
      logic [31:0] d;
      d  = $urandom;
      w0 = pmem_dpi_pkg::pmem_writes;
      issue(2, 1'b1, BASE + 32'h20, d, 8'h0F, lat);
      ref_write(BASE + 32'h20, d, 8'h0F);
      n_checks++;
      if (lat !== 4) begin n_fail++; $display("FAIL bp_latency: got %0d expected 4", lat); end
      for (int c = 0; c < 5; c++) begin
         @(posedge clk);
         #1;
         n_checks++;
         if (rsp_valid[2] !== 1'b1 || req_ready[2] !== 1'b0 || rsp_wen[2] !== 1'b1 ||
             rsp_err[2] !== 1'b0 || rsp_rdata[2] !== 32'h0) begin
            n_fail++;
            $display("FAIL bp_hold cycle %0d: got valid=%b ready=%b wen=%b err=%b rdata=%h expected 1 0 1 0 0",
                     c, rsp_valid[2], req_ready[2], rsp_wen[2], rsp_err[2], rsp_rdata[2]);
         end
      end
      n_checks++;
      if (pmem_dpi_pkg::pmem_writes - w0 !== 1) begin n_fail++; $display("FAIL bp_calls: got %0d expected 1", pmem_dpi_pkg::pmem_writes - w0); end
      consume(2);
      n_checks++;
      if (req_ready[2] !== 1'b1 || rsp_valid[2] !== 1'b0) begin
         n_fail++; $display("FAIL bp_release_idle: got ready=%b valid=%b expected ready=1 valid=0", req_ready[2], rsp_valid[2]);
      end
   endtask

   task automatic test_back_to_back();
      int acc [4];
      int n_acc;
      int unsigned r0;
      n_acc = 0;
      r0 = pmem_dpi_pkg::pmem_reads;
      @(negedge clk);
      rsp_ready[1] = 1'b1;
      req_valid[1] = 1'b1; req_wen[1] = 1'b0; req_addr[1] = BASE + 32'h10;
      req_wdata[1] = '0;   req_mask[1] = 8'h0F;
      for (int cyc = 0; cyc < 80 && n_acc < 4; cyc++) begin
         if (cyc > 0) @(negedge clk);
         if (rsp_valid[1]) begin
            n_checks++;
            if (rsp_rdata[1] !== 32'h1234_5678) begin n_fail++; $display("FAIL b2b_rdata: got %h expected 12345678", rsp_rdata[1]); end
         end
         if (req_ready[1]) begin
            acc[n_acc] = cyc;
            n_acc++;
         end
      end
      @(posedge clk);
      #1;
      req_valid[1] = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      rsp_ready[1] = 1'b0;
      n_checks += 2;
      if (n_acc !== 4) begin n_fail++; $display("FAIL b2b_accepts: got %0d expected 4", n_acc); end
      if (pmem_dpi_pkg::pmem_reads - r0 !== 4) begin n_fail++; $display("FAIL b2b_calls: got %0d expected 4", pmem_dpi_pkg::pmem_reads - r0); end
      for (int k = 0; k + 1 < n_acc; k++) begin
         n_checks++;
         if (acc[k+1] - acc[k] !== 5) begin n_fail++; $display("FAIL b2b_spacing %0d: got %0d expected 5", k, acc[k+1] - acc[k]); end
      end
   endtask

   task automatic test_reset_mid_wait();
      int unsigned w0;
      w0 = pmem_dpi_pkg::pmem_writes;
      @(negedge clk);
      req_valid[2] = 1'b1; req_wen[2] = 1'b1; req_addr[2] = BASE + 32'h30;
      req_wdata[2] = 32'h5A5A_A5A5; req_mask[2] = 8'h0F;
      @(posedge clk);
      #1;
      req_valid[2] = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #2;
      n_checks++;
      if (rsp_valid[2] !== 1'b0 || req_ready[2] !== 1'b1) begin
         n_fail++; $display("FAIL rst_mid_async: got valid=%b ready=%b expected valid=0 ready=1", rsp_valid[2], req_ready[2]);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(posedge clk);
         #1;
         n_checks++;
         if (rsp_valid[2] !== 1'b0 || req_ready[2] !== 1'b1) begin
            n_fail++; $display("FAIL rst_mid_idle cycle %0d: got valid=%b ready=%b expected valid=0 ready=1", c, rsp_valid[2], req_ready[2]);
         end
      end
      n_checks++;
      if (pmem_dpi_pkg::pmem_writes - w0 !== 0) begin n_fail++; $display("FAIL rst_mid_calls: got %0d expected 0", pmem_dpi_pkg::pmem_writes - w0); end
   endtask

   task automatic test_random_delay();
      logic [7:0]  s;
      logic        wen;
      logic [31:0] addr, wdata, exp_rdata;
      logic [7:0]  mask;
      bit          exp_err;
      int          exp_lat, lat;
      int unsigned c0;
      s = 8'hA5;
      for (int k = 0; k < 16; k++) begin
         wen   = 1'($urandom_range(0, 1));
         wdata = $urandom;
         mask  = 8'($urandom_range(1, 15));
         if ($urandom_range(0, 5) == 0)
            addr = ($urandom_range(0, 1) == 1) ? BASE - 32'(4 * $urandom_range(1, 8))
                                               : BASE + SIZE + 32'(4 * $urandom_range(0, 8));
         else
            addr = BASE + 32'(4 * $urandom_range(0, 15));
         exp_lat   = 1 + int'(s[1:0]);
         s         = lfsr_next(s);
         exp_err   = !ref_in_range(addr);
         exp_rdata = (wen || exp_err) ? 32'h0 : ref_read(addr);
         c0 = pmem_dpi_pkg::pmem_reads + pmem_dpi_pkg::pmem_writes;
         issue(3, wen, addr, wdata, mask, lat);
         if (wen && !exp_err) ref_write(addr, wdata, mask);
         n_checks += 5;
         if (lat !== exp_lat) begin n_fail++; $display("FAIL rand_latency #%0d: got %0d expected %0d", k, lat, exp_lat); end
         if (rsp_err[3] !== exp_err) begin n_fail++; $display("FAIL rand_err #%0d @%h: got %b expected %b", k, addr, rsp_err[3], exp_err); end
         if (rsp_rdata[3] !== exp_rdata) begin n_fail++; $display("FAIL rand_rdata #%0d @%h: got %h expected %h", k, addr, rsp_rdata[3], exp_rdata); end
         if (rsp_wen[3] !== wen) begin n_fail++; $display("FAIL rand_wen #%0d: got %b expected %b", k, rsp_wen[3], wen); end
         if (pmem_dpi_pkg::pmem_reads + pmem_dpi_pkg::pmem_writes - c0 !== (exp_err ? 0 : 1)) begin
            n_fail++; $display("FAIL rand_calls #%0d: got %0d expected %0d", k,
                               pmem_dpi_pkg::pmem_reads + pmem_dpi_pkg::pmem_writes - c0, exp_err ? 0 : 1);
         end
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
         consume(3);
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      test_reset();
      test_read_l1();
      test_write_read_l3();
      test_address_range();
      test_backpressure();
      test_back_to_back();
      test_reset_mid_wait();
      test_random_delay();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
